// File: rtl/led_step_scheduler.sv
// led_step_scheduler
//   Control block for an 18-bit LED pattern datapath. It debounces four
//   push-buttons, generates a periodic step tick and runs a small FSM that
//   tells the datapath when to load its seed value and when to apply an
//   operation.
//
// Ports
//   clk       : system clock, all state updates on posedge
//   rst_n     : asynchronous active-low reset
//   KEY[3:0]  : raw active-low buttons: [0] clear, [1] start/stop,
//               [2] next-mode, [3] pause/resume
//   SW[2:0]   : [1:0] manual mode select, [2] auto-cycle enable
//   step_en   : one-cycle pulse, datapath applies op
//   op[1:0]   : 00 shift right, 01 invert, 10 add 2, 11 shift left
//   load      : one-cycle pulse, datapath loads load_val
//   load_val  : constant seed 18'h3E000
//   state[1:0]: FSM state (00 IDLE, 01 RUN, 10 PAUSE, 11 LOAD)
//   mode[1:0] : current mode register
module led_step_scheduler #(
  parameter int TICK_DIV   = 5_000_000,
  parameter int DEB_CYCLES = 1000,
  parameter int AUTO_STEPS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  KEY,
  input  logic [2:0]  SW,
  output logic        step_en,
  output logic [1:0]  op,
  output logic        load,
  output logic [17:0] load_val,
  output logic [1:0]  state,
  output logic [1:0]  mode
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LOAD  = 2'b11
  } state_t;

  // ---------------------------------------------------------------------
  // Debounce: one stable level and one run-length counter per key.
  // ---------------------------------------------------------------------
  logic [3:0]    stable_q, stable_d;
  logic [DW-1:0] deb_cnt_q [4];
  logic [DW-1:0] deb_cnt_d [4];
  logic [3:0]    press_q, press_d;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (KEY[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          stable_d[i]  = KEY[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
    // Keys are active-low: a press is the stable level falling 1->0.
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 4'hF;
      press_q  <= 4'h0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // ---------------------------------------------------------------------
  // Free-running step tick, counts in every state.
  // ---------------------------------------------------------------------
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // ---------------------------------------------------------------------
  // Sequencing FSM plus mode / auto-step bookkeeping.
  // ---------------------------------------------------------------------
  state_t     state_q, state_d;
  logic       step_en_q, step_en_d;
  logic [1:0] op_q, op_d;
  logic       load_q, load_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] step_cnt_q, step_cnt_d;

  logic p_clear, p_start, p_next, p_pause, any_press;

  always_comb begin
    p_clear   = press_q[0];
    p_start   = press_q[1];
    p_next    = press_q[2];
    p_pause   = press_q[3];
    any_press = |press_q;

    state_d    = state_q;
    step_en_d  = 1'b0;
    op_d       = op_q;
    mode_d     = mode_q;
    step_cnt_d = step_cnt_q;

    // Priority within each state: clear > start > pause.
    case (state_q)
      S_IDLE: begin
        if (p_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d    = S_RUN;
        step_cnt_d = '0;
      end
      S_RUN: begin
        if (p_clear)      state_d = S_LOAD;
        else if (p_start) state_d = S_IDLE;
        else if (p_pause) state_d = S_PAUSE;
        else if (tick && !any_press) begin
          // Any accepted press on a tick cycle swallows that step.
          step_en_d = 1'b1;
          op_d      = mode_q;
        end
      end
      S_PAUSE: begin
        if (p_clear)      state_d = S_LOAD;
        else if (p_start) state_d = S_IDLE;
        else if (p_pause) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    load_d = (state_d == S_LOAD);

    // op is captured from mode_q above, so a mode change made here only
    // shows up on the following step.
    if (!SW[2]) begin
      if (tick) mode_d = SW[1:0];
    end else if (p_next) begin
      mode_d     = mode_q + 2'd1;
      step_cnt_d = '0;
    end else if (step_en_d) begin
      if (step_cnt_q == 4'(AUTO_STEPS - 1)) begin
        mode_d     = mode_q + 2'd1;
        step_cnt_d = '0;
      end else begin
        step_cnt_d = step_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      state_q    <= S_IDLE;
      step_en_q  <= 1'b0;
      op_q       <= 2'b00;
      load_q     <= 1'b0;
      mode_q     <= 2'b00;
      step_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      step_en_q  <= step_en_d;
      op_q       <= op_d;
      load_q     <= load_d;
      mode_q     <= mode_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign step_en  = step_en_q;
  assign op       = op_q;
  assign load     = load_q;
  assign load_val = 18'h3E000;
  assign state    = state_q;
  assign mode     = mode_q;

endmodule
